// File: rtl/hw_accel_pkg.sv
// Shared definitions for the accelerator pixel stages: latency, output pixel codes,
// and the 1-2-1 weighted sum used both for grayscale conversion and for Sobel taps.
package hw_accel_pkg;

  localparam int          SOBEL_LATENCY = 4;
  localparam logic [31:0] PIX_EDGE      = 32'h00FF_FFFF;
  localparam logic [31:0] PIX_NONE      = 32'h0000_0000;

  typedef logic [7:0] gray_t;

  // a + 2b + c; at most 1020, so it always fits in 10 bits
  function automatic logic [9:0] tap_sum(input gray_t a, input gray_t b, input gray_t c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic gray_t rgb_to_gray(input logic [23:0] rgb);
    logic [9:0] sum;
    sum = tap_sum(rgb[23:16], rgb[15:8], rgb[7:0]);
    return sum[9:2];
  endfunction

endpackage

// File: rtl/hw_accel_line_buffer.sv
// Two-row gray line store, one 16-bit word per column: {row y-2, row y-1}.
// Each access returns the old word and pushes the new gray in, ageing row y-1 to y-2.
module hw_accel_line_buffer
  import hw_accel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  gray_t         gray_i,
  output logic [15:0]   rd_o
);

  logic [15:0] mem [DEPTH];
  logic [15:0] rd_q;

  // Contents are deliberately not reset; rows 0-1 of each frame are masked downstream.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rd_q         <= mem[addr_i];
      mem[addr_i]  <= {mem[addr_i][7:0], gray_i};
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/hw_accel_sobel.sv
// Streaming 3x3 Sobel edge detector: RGB in, one thresholded binary pixel out per
// input pixel at fixed latency. Valid-only stream; the pipeline never stalls.
module hw_accel_sobel
  import hw_accel_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           sobel_thresh,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_in_valid,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_out_valid,
  output logic                  frame_done
);

  localparam int             XW     = $clog2(FRAME_WIDTH);
  localparam int             YW     = $clog2(FRAME_HEIGHT);
  localparam logic [XW-1:0]  X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(FRAME_HEIGHT - 1);

  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic [31:0]               thresh_q, thresh_d;
  logic                      in_last;
  gray_t                     gray_in;

  logic [SOBEL_LATENCY-1:0]  vld_sr_q;
  logic [SOBEL_LATENCY-1:0]  last_sr_q;
  logic                      v1, v3;

  gray_t                     gray1_q;
  logic [XW-1:0]             x1_q;
  logic [YW-1:0]             y1_q;
  logic [15:0]               lb_rd;

  logic [2:0][2:0][7:0]      win_q, win_d;
  logic                      border2_q, border3_q;

  logic [9:0]                col0, col2, row0, row2;
  logic signed [10:0]        gx_q, gy_q, gx_d, gy_d;
  logic [10:0]               abs_x, abs_y;
  logic [11:0]               mag;
  logic                      is_edge;
  logic [DATA_WIDTH-1:0]     pix_out_q;

  logic                      unused_pix_hi;
  assign unused_pix_hi = ^pixel_in[DATA_WIDTH-1:24];

  // Position counters and per-frame threshold latch
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    thresh_d = thresh_q;
    in_last  = pixel_in_valid && (x_q == X_LAST) && (y_q == Y_LAST);
    if (pixel_in_valid) begin
      if (x_q == '0 && y_q == '0) thresh_d = sobel_thresh;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      thresh_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      thresh_q <= thresh_d;
    end
  end

  // Valid and end-of-frame tags ride alongside the data, one bit per stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      vld_sr_q  <= {vld_sr_q[SOBEL_LATENCY-2:0], pixel_in_valid};
      last_sr_q <= {last_sr_q[SOBEL_LATENCY-2:0], in_last};
    end
  end

  assign v1 = vld_sr_q[0];
  assign v3 = vld_sr_q[2];

  // S1: gray conversion; the line-buffer access is issued on the same edge
  assign gray_in = rgb_to_gray(pixel_in[23:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray1_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else begin
      gray1_q <= gray_in;
      x1_q    <= x_q;
      y1_q    <= y_q;
    end
  end

  hw_accel_line_buffer #(
    .DEPTH (FRAME_WIDTH),
    .AW    (XW)
  ) u_line_buffer (
    .clk    (clk),
    .en_i   (pixel_in_valid),
    .addr_i (x_q),
    .gray_i (gray_in),
    .rd_o   (lb_rd)
  );

  // S2: window shift, row 0 oldest at top, column 2 newest on the right
  always_comb begin
    win_d = win_q;
    if (v1) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_rd[15:8];
      win_d[1][2] = lb_rd[7:0];
      win_d[2][2] = gray1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '0;
      border2_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      border2_q <= (x1_q < XW'(2)) || (y1_q < YW'(2));
    end
  end

  // S3: gradients as differences of weighted column / row sums
  always_comb begin
    col0 = tap_sum(win_q[0][0], win_q[1][0], win_q[2][0]);
    col2 = tap_sum(win_q[0][2], win_q[1][2], win_q[2][2]);
    row0 = tap_sum(win_q[0][0], win_q[0][1], win_q[0][2]);
    row2 = tap_sum(win_q[2][0], win_q[2][1], win_q[2][2]);
    gx_d = $signed({1'b0, col2}) - $signed({1'b0, col0});
    gy_d = $signed({1'b0, row2}) - $signed({1'b0, row0});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_q      <= '0;
      gy_q      <= '0;
      border3_q <= 1'b0;
    end else begin
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      border3_q <= border2_q;
    end
  end

  // S4: magnitude and strict threshold; output holds between valid pixels
  always_comb begin
    abs_x   = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_y   = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag     = {1'b0, abs_x} + {1'b0, abs_y};
    is_edge = !border3_q && ({20'b0, mag} > thresh_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out_q <= '0;
    end else if (v3) begin
      pix_out_q <= is_edge ? DATA_WIDTH'(PIX_EDGE) : DATA_WIDTH'(PIX_NONE);
    end
  end

  assign pixel_out       = pix_out_q;
  assign pixel_out_valid = vld_sr_q[SOBEL_LATENCY-1];
  assign frame_done      = last_sr_q[SOBEL_LATENCY-1];

endmodule

// File: tb/tb_hw_accel_sobel.sv
// Bench for hw_accel_sobel on an 8x6 frame: directed edge/step images plus random frames,
// scored against an image-level Sobel model with per-pixel latency tracking.
module tb_hw_accel_sobel;

  localparam int W = 8;
  localparam int H = 6;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sobel_thresh = '0;
  logic [31:0] pixel_in = '0;
  logic        pixel_in_valid = 1'b0;
  logic [31:0] pixel_out;
  logic        pixel_out_valid;
  logic        frame_done;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [31:0] exp_q[$];
  logic        exp_done_q[$];
  int          t_q[$];
  logic [31:0] last_exp = '0;
  logic [31:0] frm [H][W];

  hw_accel_sobel #(
    .DATA_WIDTH   (32),
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sobel_thresh    (sobel_thresh),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .frame_done      (frame_done)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // reference model: plain image arithmetic on the stored frame
  function automatic int gray_of(input logic [31:0] p);
    return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
  endfunction

  function automatic logic [31:0] model_pix(input int x, input int y, input logic [31:0] th);
    int g[3][3];
    int gx, gy, mag;
    if (x < 2 || y < 2) return 32'h0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[r][c] = gray_of(frm[y-2+r][x-2+c]);
    gx  = (g[0][2] + 2*g[1][2] + g[2][2]) - (g[0][0] + 2*g[1][0] + g[2][0]);
    gy  = (g[2][0] + 2*g[2][1] + g[2][2]) - (g[0][0] + 2*g[0][1] + g[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (longint'(mag) > longint'(th)) ? 32'h00FF_FFFF : 32'h0;
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    logic        d;
    int          t;
    if (rst) begin
      check_eq("rst_valid", 32'(pixel_out_valid), 32'h0);
      check_eq("rst_pix", pixel_out, 32'h0);
      check_eq("rst_done", 32'(frame_done), 32'h0);
    end else if (pixel_out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_out", 32'(pixel_out_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        d = exp_done_q.pop_front();
        t = t_q.pop_front();
        check_eq("pix", pixel_out, e);
        check_eq("done", 32'(frame_done), 32'(d));
        check_eq("lat", 32'(cyc - t), 32'(LAT));
        last_exp = e;
      end
    end else begin
      check_eq("done_idle", 32'(frame_done), 32'h0);
      check_eq("hold", pixel_out, last_exp);
    end
  end

  // driver tasks
  task automatic idle(input int n);
    pixel_in_valid = 1'b0;
    repeat (n) begin
      pixel_in = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic fill(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0:       frm[y][x] = 32'h0080_8080;
          1:       frm[y][x] = (x >= 4) ? 32'h00FF_FFFF : 32'h0;
          2:       frm[y][x] = (y >= 3) ? 32'h0019_1919 : 32'h0;
          default: frm[y][x] = $urandom;
        endcase
  endtask

  // vmode: 0 continuous, 1 pattern 1,0,0, 2 random gaps; npix truncates the frame
  task automatic send_frame(input logic [31:0] th, input logic [31:0] th_mid, input int mid_idx,
                            input int vmode, input int npix);
    int idx, gaps;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        idx = y * W + x;
        if (idx < npix) begin
          if (idx == 0) sobel_thresh = th;
          else if (idx == mid_idx) sobel_thresh = th_mid;
          exp_q.push_back(model_pix(x, y, th));
          exp_done_q.push_back(x == W-1 && y == H-1);
          t_q.push_back(cyc);
          pixel_in       = frm[y][x];
          pixel_in_valid = 1'b1;
          @(negedge clk);
          gaps = (vmode == 1) ? 2 : (vmode == 2) ? int'($urandom_range(0, 2)) : 0;
          idle(gaps);
        end
      end
    end
    pixel_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst            = 1'b1;
    pixel_in_valid = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    t_q.delete();
    last_exp = '0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int wait_cyc;
    // reset held while valid toggles: outputs must stay quiet
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      pixel_in       = $urandom;
      pixel_in_valid = i[0];
      @(negedge clk);
    end
    pixel_in_valid = 1'b0;
    #2;
    rst = 1'b0;
    @(negedge clk);

    fill(0); send_frame(100, 100, -1, 0, W*H); idle(3);
    fill(1); send_frame(100, 100, -1, 0, W*H); idle(3);
    fill(1); send_frame(100, 100, -1, 1, W*H); idle(3);

    // horizontal step: gradient of exactly 100 at the threshold boundary
    fill(2);
    send_frame(100, 100, -1, 0, W*H);
    send_frame(99, 99, -1, 0, W*H);
    send_frame(99, 200, 2*W+3, 0, W*H);
    idle(3);

    // reset mid-frame, then two back-to-back frames
    fill(1);
    send_frame(100, 100, -1, 0, 20);
    do_reset();
    send_frame(100, 100, -1, 0, W*H);
    send_frame(100, 100, -1, 0, W*H);
    idle(3);

    for (int f = 0; f < 6; f++) begin
      fill(3);
      send_frame((f == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1200)),
                 32'($urandom_range(0, 1200)), int'($urandom_range(1, W*H-1)),
                 (f % 2 == 0) ? 0 : 2, W*H);
      idle(3);
    end

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
